// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC definitions: port codes, flit types, flit field positions, XY route helper
//
// Purpose: single source of truth for encodings shared by the input port
// unit and the switch allocator.
package noc_pkg;

    // Output port codes seen by the switch allocator; PORT_NONE means "no request".
    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4,
        PORT_NONE  = 3'd7
    } port_e;

    // Flit type carried in the top two bits of every flit.
    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_TAIL   = 2'b01,
        FLIT_HEAD   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flit_type_e;

    // Input port unit wormhole state.
    typedef enum logic {
        IPU_IDLE   = 1'b0,
        IPU_ACTIVE = 1'b1
    } ipu_state_e;

    // Flit field positions.
    localparam int FLIT_TYPE_HI = 33;
    localparam int FLIT_TYPE_LO = 32;
    localparam int FLIT_DX_HI   = 31;
    localparam int FLIT_DX_LO   = 28;
    localparam int FLIT_DY_HI   = 27;
    localparam int FLIT_DY_LO   = 24;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic port_e xy_route(
        input logic [3:0] dest_x,
        input logic [3:0] dest_y,
        input logic [3:0] cur_x,
        input logic [3:0] cur_y
    );
        port_e port;
        if (dest_x > cur_x) begin
            port = PORT_EAST;
        end else if (dest_x < cur_x) begin
            port = PORT_WEST;
        end else if (dest_y > cur_y) begin
            port = PORT_NORTH;
        end else if (dest_y < cur_y) begin
            port = PORT_SOUTH;
        end else begin
            port = PORT_LOCAL;
        end
        return port;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - synchronous flit buffer with full/empty flags
//
// Purpose: FIFO_DEPTH-entry first-word-fall-through buffer; rd_data always
// shows the oldest entry while empty is low.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset (clears pointers/count)
//   wr_data/wr_en - write side; writes while full are ignored
//   full          - no free entry
//   rd_data/rd_en - read side; rd_en pops the front entry, ignored while empty
//   empty         - no stored entry
module flit_fifo #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              full,
    output logic [FLIT_W-1:0] rd_data,
    input  logic              rd_en,
    output logic              empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/input_port_unit.sv
// rtl/input_port_unit.sv - router input port: flit buffer, XY route computation, wormhole FSM
//
// Purpose: buffers flits from the upstream link, routes each packet head by
// XY routing, holds the route until the tail (wormhole) and forwards flits
// to the crossbar on allocator grants.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   flit_in, valid_in   - upstream flit; accepted when ready_out is high
//   ready_out           - buffer not full
//   request             - requested output port; 3'b111 = no request
//   ack                 - allocator grant for the current request
//   flit_out, valid_out - registered flit toward the crossbar
//   err                 - one-cycle pulse when an orphan body/tail is dropped
module input_port_unit
    import noc_pkg::*;
#(
    parameter int FLIT_W     = 34,
    parameter int FIFO_DEPTH = 4,
    parameter int CUR_X      = 0,
    parameter int CUR_Y      = 0,
    parameter int N_REGISTER = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_W-1:0]     flit_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [N_REGISTER-1:0] request,
    input  logic                  ack,
    output logic [FLIT_W-1:0]     flit_out,
    output logic                  valid_out,
    output logic                  err
);

    localparam logic [3:0] CUR_X4 = 4'(CUR_X);
    localparam logic [3:0] CUR_Y4 = 4'(CUR_Y);

    logic [FLIT_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    ipu_state_e        state_q, state_d;
    port_e             route_q, route_d;
    logic [FLIT_W-1:0] flit_out_q, flit_out_d;
    logic              valid_out_q, valid_out_d;
    logic              err_q, err_d;

    flit_type_e        front_type;
    port_e             req_port;

    flit_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (flit_in),
        .wr_en   (valid_in),
        .full    (fifo_full),
        .rd_data (fifo_rd_data),
        .rd_en   (fifo_pop),
        .empty   (fifo_empty)
    );

    assign front_type = flit_type_e'(fifo_rd_data[FLIT_TYPE_HI:FLIT_TYPE_LO]);

    // A request is only raised while a flit of the open packet is waiting.
    assign req_port  = (state_q == IPU_ACTIVE && !fifo_empty) ? route_q : PORT_NONE;

    assign ready_out = !fifo_full;
    assign request   = N_REGISTER'(req_port);
    assign flit_out  = flit_out_q;
    assign valid_out = valid_out_q;
    assign err       = err_q;

    always_comb begin
        state_d     = state_q;
        route_d     = route_q;
        flit_out_d  = flit_out_q;
        valid_out_d = 1'b0;
        err_d       = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            IPU_IDLE: begin
                if (!fifo_empty) begin
                    if (front_type == FLIT_HEAD || front_type == FLIT_SINGLE) begin
                        // Route is computed here; the head itself stays queued
                        // and is forwarded from ACTIVE like any other flit.
                        route_d = xy_route(fifo_rd_data[FLIT_DX_HI:FLIT_DX_LO],
                                           fifo_rd_data[FLIT_DY_HI:FLIT_DY_LO],
                                           CUR_X4, CUR_Y4);
                        state_d = IPU_ACTIVE;
                    end else begin
                        // Body/tail with no open packet: drop and flag it.
                        fifo_pop = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end

            IPU_ACTIVE: begin
                if (req_port != PORT_NONE && ack) begin
                    fifo_pop    = 1'b1;
                    flit_out_d  = fifo_rd_data;
                    valid_out_d = 1'b1;
                    if (front_type == FLIT_TAIL || front_type == FLIT_SINGLE) begin
                        state_d = IPU_IDLE;
                        route_d = PORT_NONE;
                    end
                end
            end

            default: begin
                state_d = IPU_IDLE;
                route_d = PORT_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IPU_IDLE;
            route_q     <= PORT_NONE;
            flit_out_q  <= '0;
            valid_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            route_q     <= route_d;
            flit_out_q  <= flit_out_d;
            valid_out_q <= valid_out_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_input_port_unit.sv
// tb/tb_input_port_unit.sv - self-checking bench for input_port_unit at router (1,1)
module tb_input_port_unit;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [33:0] flit_in = '0;
    logic        valid_in = 1'b0;
    logic        ready_out;
    logic [2:0]  request;
    logic        ack = 1'b0;
    logic [33:0] flit_out;
    logic        valid_out;
    logic        err;

    int checks = 0;
    int errors = 0;

    input_port_unit #(
        .FLIT_W     (34),
        .FIFO_DEPTH (4),
        .CUR_X      (1),
        .CUR_Y      (1),
        .N_REGISTER (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flit_in   (flit_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .request   (request),
        .ack       (ack),
        .flit_out  (flit_out),
        .valid_out (valid_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

    function automatic logic [33:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                       input logic [3:0] dy, input logic [23:0] p);
        return {t, dx, dy, p};
    endfunction

    // Reference XY routing for a router at (1,1).
    function automatic logic [2:0] ref_route(input logic [3:0] dx, input logic [3:0] dy);
        if (dx > 4'd1) return 3'd2;
        if (dx < 4'd1) return 3'd4;
        if (dy > 4'd1) return 3'd1;
        if (dy < 4'd1) return 3'd3;
        return 3'd0;
    endfunction

    task automatic apply_reset;
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0; ack = 1'b0; flit_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b0; ack = 1'b0;
        #1;
        checks++; if (request !== 3'd7) begin errors++; $display("FAIL reset_request: got %0d expected 7", request); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %0b expected 0", valid_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_out: got %0b expected 1", ready_out); end
        checks++; if (flit_out !== 34'd0) begin errors++; $display("FAIL reset_flit_out: got %0h expected 0", flit_out); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single;
        logic [33:0] f;
        apply_reset;
        f = mk(T_SINGLE, 4'd3, 4'd0, 24'($urandom));
        flit_in = f; valid_in = 1'b1; ack = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (request !== 3'd7) begin errors++; $display("FAIL single_idle_request: got %0d expected 7", request); end
        @(negedge clk);
        checks++; if (request !== 3'd2) begin errors++; $display("FAIL single_request: got %0d expected 2", request); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b expected 0", valid_out); end
        @(negedge clk);
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL single_valid_out: got %0b expected 1", valid_out); end
        checks++; if (flit_out !== f) begin errors++; $display("FAIL single_flit_out: got %0h expected %0h", flit_out, f); end
        checks++; if (request !== 3'd7) begin errors++; $display("FAIL single_request_after: got %0d expected 7", request); end
        @(negedge clk);
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %0b expected 0", valid_out); end
        ack = 1'b0;
    endtask

    task automatic test_packet;
        logic [33:0] f [4];
        int n, first, last;
        apply_reset;
        f[0] = mk(T_HEAD, 4'd1, 4'd1, 24'($urandom));
        f[1] = mk(T_BODY, 4'($urandom), 4'($urandom), 24'($urandom));
        f[2] = mk(T_BODY, 4'($urandom), 4'($urandom), 24'($urandom));
        f[3] = mk(T_TAIL, 4'($urandom), 4'($urandom), 24'($urandom));
        ack = 1'b1; n = 0; first = -1; last = -1;
        for (int c = 0; c < 10; c++) begin
            valid_in = (c < 4);
            if (c < 4) flit_in = f[c];
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (n < 4) begin
                    checks++; if (flit_out !== f[n]) begin errors++; $display("FAIL packet_flit%0d: got %0h expected %0h", n, flit_out, f[n]); end
                end
                if (first < 0) first = c;
                last = c;
                n++;
            end
            if (request !== 3'd7) begin
                checks++; if (request !== 3'd0) begin errors++; $display("FAIL packet_request: got %0d expected 0", request); end
            end
        end
        valid_in = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL packet_count: got %0d expected 4", n); end
        checks++; if (last - first != 3) begin errors++; $display("FAIL packet_consecutive: got span %0d expected 3", last - first); end
        checks++; if (request !== 3'd7) begin errors++; $display("FAIL packet_request_after: got %0d expected 7", request); end
        ack = 1'b0;
    endtask

    task automatic test_backpressure;
        logic [33:0] f [5];
        int n;
        apply_reset;
        f[0] = mk(T_HEAD, 4'd3, 4'd1, 24'($urandom));
        for (int i = 1; i < 4; i++) f[i] = mk(T_BODY, 4'd0, 4'd0, 24'($urandom));
        f[4] = mk(T_TAIL, 4'd0, 4'd0, 24'($urandom));
        ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flit_in = f[i]; valid_in = 1'b1;
            @(negedge clk);
            if (i < 3) begin
                checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %0b expected 1", i, ready_out); end
            end else begin
                checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bp_full_%0d: got %0b expected 0", i, ready_out); end
            end
        end
        valid_in = 1'b0;
        checks++; if (request !== 3'd2) begin errors++; $display("FAIL bp_request: got %0d expected 2", request); end
        ack = 1'b1; n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (n < 4) begin
                    checks++; if (flit_out !== f[n]) begin errors++; $display("FAIL bp_flit%0d: got %0h expected %0h", n, flit_out, f[n]); end
                end
                n++;
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL bp_drain_count: got %0d expected 4", n); end
        checks++; if (request !== 3'd7) begin errors++; $display("FAIL bp_request_empty: got %0d expected 7", request); end
        ack = 1'b0;
    endtask

    task automatic test_orphan;
        logic [33:0] s;
        int n_err, n_val;
        logic seen;
        apply_reset;
        ack = 1'b1;
        flit_in = mk(T_BODY, 4'd2, 4'd2, 24'($urandom)); valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        n_err = 0; n_val = 0;
        for (int c = 0; c < 6; c++) begin
            if (err === 1'b1) n_err++;
            if (valid_out === 1'b1) n_val++;
            if (request !== 3'd7) begin
                checks++; errors++; $display("FAIL orphan_request: got %0d expected 7", request);
            end
            @(negedge clk);
        end
        checks++; if (n_err != 1) begin errors++; $display("FAIL orphan_err_pulses: got %0d expected 1", n_err); end
        checks++; if (n_val != 0) begin errors++; $display("FAIL orphan_valid_out: got %0d expected 0", n_val); end
        s = mk(T_SINGLE, 4'd1, 4'd1, 24'($urandom));
        flit_in = s; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (valid_out === 1'b1) begin
                seen = 1'b1;
                checks++; if (flit_out !== s) begin errors++; $display("FAIL orphan_next_flit: got %0h expected %0h", flit_out, s); end
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL orphan_next_seen: got 0 expected 1"); end
        ack = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [33:0] h;
        int n;
        logic seen_v, saw_req;
        apply_reset;
        ack = 1'b1; seen_v = 1'b0;
        for (int c = 0; c < 10 && !seen_v; c++) begin
            valid_in = (c < 3);
            flit_in = (c == 0) ? mk(T_HEAD, 4'd3, 4'd2, 24'($urandom)) : mk(T_BODY, 4'd0, 4'd0, 24'($urandom));
            @(negedge clk);
            if (valid_out === 1'b1) seen_v = 1'b1;
        end
        valid_in = 1'b0;
        checks++; if (!seen_v) begin errors++; $display("FAIL midrst_prestate: got 0 expected valid_out 1"); end
        #2 rst = 1'b0;
        #1;
        checks++; if (request !== 3'd7) begin errors++; $display("FAIL midrst_request: got %0d expected 7", request); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL midrst_valid_out: got %0b expected 0", valid_out); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL midrst_ready_out: got %0b expected 1", ready_out); end
        checks++; if (flit_out !== 34'd0) begin errors++; $display("FAIL midrst_flit_out: got %0h expected 0", flit_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %0b expected 0", err); end
        @(negedge clk);
        rst = 1'b1;
        h = mk(T_HEAD, 4'd1, 4'd3, 24'($urandom));
        flit_in = h; valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        n = 0; saw_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (request !== 3'd7) begin
                saw_req = 1'b1;
                checks++; if (request !== 3'd1) begin errors++; $display("FAIL midrst_new_request: got %0d expected 1", request); end
            end
            @(negedge clk);
            if (valid_out === 1'b1) begin
                if (n == 0) begin
                    checks++; if (flit_out !== h) begin errors++; $display("FAIL midrst_new_flit: got %0h expected %0h", flit_out, h); end
                end
                n++;
            end
        end
        checks++; if (!saw_req) begin errors++; $display("FAIL midrst_req_seen: got 0 expected 1"); end
        checks++; if (n != 1) begin errors++; $display("FAIL midrst_out_count: got %0d expected 1", n); end
        ack = 1'b0;
    endtask

    task automatic test_ack_toggle;
        logic [33:0] f [3];
        logic [4:0]  pat;
        int pops;
        apply_reset;
        f[0] = mk(T_HEAD, 4'd0, 4'd2, 24'($urandom));
        f[1] = mk(T_BODY, 4'd5, 4'd5, 24'($urandom));
        f[2] = mk(T_TAIL, 4'd5, 4'd5, 24'($urandom));
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flit_in = f[i]; valid_in = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        pat = 5'b10101;
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            if (pops < 3) begin
                checks++; if (request !== 3'd4) begin errors++; $display("FAIL toggle_request_%0d: got %0d expected 4", i, request); end
            end else begin
                checks++; if (request !== 3'd7) begin errors++; $display("FAIL toggle_request_end: got %0d expected 7", request); end
            end
            ack = pat[4 - i];
            @(negedge clk);
            checks++; if (valid_out !== pat[4 - i]) begin errors++; $display("FAIL toggle_valid_%0d: got %0b expected %0b", i, valid_out, pat[4 - i]); end
            if (pat[4 - i]) begin
                checks++; if (flit_out !== f[pops]) begin errors++; $display("FAIL toggle_flit_%0d: got %0h expected %0h", pops, flit_out, f[pops]); end
                pops++;
            end
        end
        checks++; if (request !== 3'd7) begin errors++; $display("FAIL toggle_request_after: got %0d expected 7", request); end
        ack = 1'b0;
    endtask

    // Random traffic against a stream-level model: every accepted flit is
    // either an orphan (expected err) or forwarded in order under its packet route.
    task automatic test_random;
        logic [33:0] gen_q [$];
        logic [33:0] exp_q [$];
        logic [2:0]  rte_q [$];
        logic        in_pkt;
        logic [2:0]  cur_rte;
        int          orphans, errs_seen, r, nb;
        logic        exp_v, v, a, rdy, drain;
        logic [33:0] exp_f, f;
        logic [2:0]  rq;
        logic [1:0]  t;
        logic [3:0]  dx, dy;
        apply_reset;
        in_pkt = 1'b0; cur_rte = 3'd0; orphans = 0; errs_seen = 0;
        exp_v = 1'b0; exp_f = '0;
        for (int cyc = 0; cyc < 464; cyc++) begin
            drain = (cyc >= 400);
            if (gen_q.size() == 0) begin
                r = int'($urandom % 8); dx = 4'($urandom % 4); dy = 4'($urandom % 4);
                if (r == 0) begin
                    gen_q.push_back(mk(($urandom % 2) ? T_TAIL : T_BODY, dx, dy, 24'($urandom)));
                end else if (r < 3) begin
                    gen_q.push_back(mk(T_SINGLE, dx, dy, 24'($urandom)));
                end else begin
                    gen_q.push_back(mk(T_HEAD, dx, dy, 24'($urandom)));
                    nb = int'($urandom % 4);
                    for (int b = 0; b < nb; b++) gen_q.push_back(mk(T_BODY, 4'($urandom), 4'($urandom), 24'($urandom)));
                    gen_q.push_back(mk(T_TAIL, 4'($urandom), 4'($urandom), 24'($urandom)));
                end
            end
            rq = request; rdy = ready_out;
            checks++; if (valid_out !== exp_v) begin errors++; $display("FAIL rand_valid_out cyc %0d: got %0b expected %0b", cyc, valid_out, exp_v); end
            if (exp_v) begin
                checks++; if (flit_out !== exp_f) begin errors++; $display("FAIL rand_flit_out cyc %0d: got %0h expected %0h", cyc, flit_out, exp_f); end
            end
            if (err === 1'b1) errs_seen++;
            if (rq !== 3'd7) begin
                checks++;
                if (rte_q.size() == 0) begin
                    errors++; $display("FAIL rand_request cyc %0d: got %0d expected 7 (nothing queued)", cyc, rq);
                end else if (rq !== rte_q[0]) begin
                    errors++; $display("FAIL rand_request cyc %0d: got %0d expected %0d", cyc, rq, rte_q[0]);
                end
            end
            v = !drain && ($urandom % 3 != 0);
            a = drain || ($urandom % 4 != 0);
            f = gen_q[0];
            valid_in = v; flit_in = f; ack = a;
            if (v && rdy) begin
                void'(gen_q.pop_front());
                t = f[33:32];
                if (!in_pkt) begin
                    if (t == T_HEAD || t == T_SINGLE) begin
                        cur_rte = ref_route(f[31:28], f[27:24]);
                        exp_q.push_back(f); rte_q.push_back(cur_rte);
                        in_pkt = (t == T_HEAD);
                    end else begin
                        orphans++;
                    end
                end else begin
                    exp_q.push_back(f); rte_q.push_back(cur_rte);
                    if (t == T_TAIL || t == T_SINGLE) in_pkt = 1'b0;
                end
            end
            if (rq !== 3'd7 && a && exp_q.size() > 0) begin
                exp_v = 1'b1;
                exp_f = exp_q.pop_front();
                void'(rte_q.pop_front());
            end else begin
                exp_v = 1'b0;
            end
            @(negedge clk);
        end
        valid_in = 1'b0; ack = 1'b0;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d flits left expected 0", exp_q.size()); end
        checks++; if (errs_seen != orphans) begin errors++; $display("FAIL rand_err_count: got %0d expected %0d", errs_seen, orphans); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_packet;
        test_backpressure;
        test_orphan;
        test_reset_mid;
        test_ack_toggle;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_port_unit.md
INPUT_PORT_UNIT -- requirements
Module: input_port_unit

Interface
REQ-001 SHALL have parameter FLIT_W, default 34, the flit width; bits [33:32] are the type, [31:28] are dest X and [27:24] are dest Y.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the buffer depth in flits (a power of two).
REQ-003 SHALL have parameters CUR_X and CUR_Y, default 0 each, the 4-bit coordinates of this router.
REQ-004 SHALL have parameter N_REGISTER, default 3, the request code width.
REQ-005 SHALL provide: clk  input  1  single clock; all state is updated on the rising edge.
REQ-006 SHALL provide: rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide: flit_in  input  FLIT_W  flit arriving from the upstream link.
REQ-008 SHALL provide: valid_in  input  1  flit_in is valid this cycle.
REQ-009 SHALL provide: ready_out  output  1  buffer can accept a flit (high when the FIFO is not full).
REQ-010 SHALL provide: request  output  N_REGISTER  requested output port to the switch allocator; 3'b111 means no request.
REQ-011 SHALL provide: ack  input  1  allocator grant for the current request.
REQ-012 SHALL provide: flit_out  output  FLIT_W  registered flit toward the crossbar.
REQ-013 SHALL provide: valid_out  output  1  flit_out is valid this cycle.
REQ-014 SHALL provide: err  output  1  one-cycle pulse when an orphan flit is dropped.

Function
REQ-015 Port codes SHALL be LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4 and NONE=7.
REQ-016 Flit types SHALL be BODY=00, TAIL=01, HEAD=10 and SINGLE=11.
REQ-017 A push SHALL occur when valid_in=1 and the FIFO is not full; valid_in while full SHALL be ignored, with the flit lost and the count unchanged.
REQ-018 Push and pop in the same cycle SHALL both occur and leave the count unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have two states, IDLE and ACTIVE.
REQ-020 In IDLE with a HEAD or SINGLE flit at the front, the unit SHALL load route_reg by XY routing and enter ACTIVE at the next edge, without popping.
REQ-021 XY routing SHALL select, in priority order:
- EAST if destX > CUR_X, WEST if destX < CUR_X;
- otherwise NORTH if destY > CUR_Y, SOUTH if destY < CUR_Y;
- otherwise LOCAL.
All comparisons are unsigned 4-bit.
REQ-022 In IDLE with a BODY or TAIL flit at the front, the unit SHALL pop and discard it and pulse err for one cycle.
REQ-023 In IDLE, request SHALL be 3'b111.
REQ-024 In ACTIVE, request SHALL equal route_reg while the FIFO is non-empty, and 3'b111 while it is empty.
REQ-025 In ACTIVE, when request != 3'b111 and ack=1, the front flit SHALL be popped and registered onto flit_out, with valid_out=1 in the next cycle.
REQ-026 When no pop occurs, valid_out SHALL be 0 in the next cycle.
REQ-027 A popped TAIL or SINGLE flit SHALL return the FSM to IDLE at the same edge, so a new head needs at least one IDLE cycle before it is routed.
REQ-028 route_reg SHALL stay constant from the head until the tail, giving wormhole routing.
REQ-029 ack=1 while request=3'b111 SHALL be ignored.
REQ-030 Latency SHALL be: head written at edge k -> request valid after edge k+1 -> with ack, flit_out valid after edge k+2.
REQ-031 Sustained ack SHALL give one flit per cycle.

Reset
REQ-032 Assertion of rst (low) SHALL immediately clear the FIFO pointers and count and put the FSM in IDLE.
REQ-033 During reset, route_reg SHALL be NONE, request 3'b111, flit_out 0, valid_out 0, err 0 and ready_out 1.
REQ-034 Reset in mid-packet SHALL discard all buffered flits and wormhole state, with no partial output afterwards.
REQ-035 Release of reset SHALL be sampled synchronously, and the first push SHALL be accepted at the first edge with rst high.

Structure
REQ-036 Port codes, flit type codes and flit field positions SHALL live in a shared NoC definitions package/include, also used by switch_allocator.
REQ-037 The buffer SHALL be a sub-module flit_fifo (synchronous FIFO with full/empty), instantiated once.
REQ-038 The FSM, route computation and output register SHALL live in input_port_unit.

Verification
REQ-039 Scenario: CUR=(1,1), SINGLE flit dest (3,0), ack tied 1 -> request=2 one cycle after the write; flit_out valid two cycles after the write; FSM then IDLE.
REQ-040 Scenario: HEAD dest (1,1), two BODY flits, TAIL, back-to-back, ack=1 -> request=0 throughout; four consecutive valid_out cycles in order; request=7 after the tail.
REQ-041 Scenario: ack held 0 while 5 flits are offered with FIFO_DEPTH=4 -> ready_out=0 after the 4th; the 5th is dropped; raising ack drains exactly 4 flits.
REQ-042 Scenario: BODY flit arrives in IDLE -> err pulses once; no request; the FIFO is empty afterwards.
REQ-043 Scenario: rst driven low mid-packet, between clock edges -> outputs reach their reset values immediately; the next HEAD after release routes correctly.
REQ-044 Scenario: HEAD dest (0,2) at CUR=(1,1) with ack toggling 1,0,1 -> request=4 is held steady; flits are popped only on ack=1 cycles.
